// File: rtl/rv_multicycle_ctrl.sv
//==============================================================================
// Module      : rv_multicycle_ctrl
// Description : Multi-cycle RISC-V control FSM (fetch/decode/execute/mem/wb)
//               with memory-timeout and illegal-opcode traps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [6:0]       opcode_in,
    input  logic [2:0]       funct3_in,
    input  logic             imem_ready_in,
    input  logic             dmem_ready_in,
    input  logic             branch_taken_in,
    output logic             imem_req_out,
    output logic             ir_write_out,
    output logic             dmem_req_out,
    output logic             dmem_we_out,
    output logic             alu_src_b_sel_out,
    output logic [1:0]       alu_op_out,
    output logic             reg_write_out,
    output logic             pc_write_out,
    output logic             pc_src_out,
    output logic [2:0]       state_out,
    output logic             trap_out,
    output logic [1:0]       trap_cause_out,
    output logic [CNT_W-1:0] instret_out
);

    localparam int              TW       = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0]   TO_LIMIT = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_R      = 3'd0,
        K_I      = 3'd1,
        K_LOAD   = 3'd2,
        K_STORE  = 3'd3,
        K_BRANCH = 3'd4
    } cls_t;

    state_t           r_state;
    cls_t             r_cls;
    logic [TW-1:0]    r_cnt;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_instret;

    state_t     w_next_state;
    cls_t       w_dec_cls;
    logic       w_illegal;
    logic [1:0] w_next_cause;
    logic       w_retire;
    logic       w_timeout;
    logic       w_imem_req, w_ir_write, w_dmem_req, w_dmem_we;
    logic       w_src_b, w_reg_write, w_pc_write, w_pc_src, w_trap;
    logic [1:0] w_alu_op;

    // funct3 is consumed by the ALU decoder downstream, not by sequencing
    logic w_unused;
    assign w_unused = ^funct3_in;

    assign w_timeout = (r_cnt == TO_LIMIT);

    always_comb begin
        w_dec_cls = K_R;
        w_illegal = 1'b0;
        case (opcode_in)
            7'b0110011: w_dec_cls = K_R;
            7'b0010011: w_dec_cls = K_I;
            7'b0000011: w_dec_cls = K_LOAD;
            7'b0100011: w_dec_cls = K_STORE;
            7'b1100011: w_dec_cls = K_BRANCH;
            default:    w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        w_retire     = 1'b0;
        w_imem_req   = 1'b0;
        w_ir_write   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_src_b      = 1'b0;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_trap       = 1'b0;

        // ALU controls stay stable from EXECUTE through WB of one instruction
        if (r_state == S_EXECUTE || r_state == S_MEM || r_state == S_WB) begin
            case (r_cls)
                K_R:      begin w_src_b = 1'b0; w_alu_op = 2'b10; end
                K_I:      begin w_src_b = 1'b1; w_alu_op = 2'b10; end
                K_LOAD,
                K_STORE:  begin w_src_b = 1'b1; w_alu_op = 2'b00; end
                K_BRANCH: begin w_src_b = 1'b0; w_alu_op = 2'b01; end
                default:  begin w_src_b = 1'b0; w_alu_op = 2'b00; end
            endcase
        end

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready_in) begin
                    w_ir_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'b10;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'b01;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (r_cls == K_BRANCH) begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = branch_taken_in;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (r_cls == K_LOAD || r_cls == K_STORE) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_cls == K_STORE);
                if (dmem_ready_in) begin
                    if (r_cls == K_STORE) begin
                        w_pc_write   = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'b11;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                w_trap = 1'b1;
            end
            default: begin
                w_next_state = S_TRAP;
                w_next_cause = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_FETCH;
            r_cls     <= K_R;
            r_cnt     <= '0;
            r_cause   <= 2'b00;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_next_cause;
            if (w_retire)
                r_instret <= r_instret + 1'b1;
            if (r_state == S_DECODE)
                r_cls <= w_dec_cls;
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if ((r_state == S_FETCH && !imem_ready_in) ||
                     (r_state == S_MEM   && !dmem_ready_in))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign imem_req_out      = w_imem_req  & ~rst_in;
    assign ir_write_out      = w_ir_write  & ~rst_in;
    assign dmem_req_out      = w_dmem_req  & ~rst_in;
    assign dmem_we_out       = w_dmem_we   & ~rst_in;
    assign alu_src_b_sel_out = w_src_b     & ~rst_in;
    assign alu_op_out        = w_alu_op    & {2{~rst_in}};
    assign reg_write_out     = w_reg_write & ~rst_in;
    assign pc_write_out      = w_pc_write  & ~rst_in;
    assign pc_src_out        = w_pc_src    & ~rst_in;
    assign trap_out          = w_trap      & ~rst_in;
    assign trap_cause_out    = r_cause     & {2{~rst_in}};
    assign state_out         = r_state;
    assign instret_out       = r_instret;

endmodule

`default_nettype wire
